// File: rtl/sm4_inv_sbox_engine.sv
// sm4_inv_sbox_engine
//   Self-initialising SM4 inverse S-box lookup engine. After reset, each cycle
//   one counter value x is run through the forward SM4 S-box and stored as
//   table[S(x)] = x. That takes 256 cycles. The engine then serves one inverse
//   lookup per cycle over a valid/ready stream.
//
// Parameters
//   INIT_CHECK : 1 = keep a written-bitmap and flag duplicate forward outputs
//                during the table build (init_err); 0 = no bitmap, init_err = 0.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   in_valid/in_ready : request handshake; in_byte is the S-box output y
//   out_valid/out_ready, out_byte : result handshake; out_byte = x with S(x) = y
//   init_done         : table build complete, lookups enabled
//   init_err          : sticky duplicate-detected flag (cleared only by rst)
module sm4_inv_sbox_engine #(
  parameter bit INIT_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       init_done,
  output logic       init_err
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       out_valid_q;
  logic [7:0] out_byte_q;
  logic [7:0] tbl_q [256];
  logic [7:0] fwd_y;
  logic       accept;

  // Forward S-box image of the sweep counter; this is the table write address.
  assign fwd_y = SBOX[cnt_q];
  assign cnt_d = cnt_q + 8'd1;

  // in_ready looks at out_ready combinationally so a full output register can
  // drain and refill on the same edge (full throughput without a skid buffer).
  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign init_done = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == 8'hFF) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_byte_q  <= tbl_q[in_byte];
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Table storage carries no reset; it is fully rewritten after every reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_INIT)) begin
      tbl_q[fwd_y] <= cnt_q;
    end
  end

  generate
    if (INIT_CHECK) begin : g_check
      logic [255:0] bitmap_q;
      logic         err_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          bitmap_q <= '0;
          err_q    <= 1'b0;
        end else if (state_q == ST_INIT) begin
          // A second write to the same entry means the forward map is not
          // a permutation, so some inverse entry is left stale.
          if (bitmap_q[fwd_y]) begin
            err_q <= 1'b1;
          end
          bitmap_q[fwd_y] <= 1'b1;
        end
      end

      assign init_err = err_q;
    end else begin : g_nocheck
      assign init_err = 1'b0;
    end
  endgenerate

endmodule
